hazard_ctrl_mc: RTL

//  Successor to the single-cycle load-use/branch hazard unit. Sits in ID beside the decoder.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_ctrl_mc_if.sv | 50 +++++
 rtl/hazard_cmp.sv | 19 +
 rtl/hazard_ctrl_mc.sv | 113 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the multi-cycle hazard controller.
package hazard_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ctrl_sel;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_en;
        logic stall;
    } ctl_t;

    localparam ctl_t CTL_RST    = 7'b0001100;
    localparam ctl_t CTL_FREEZE = 7'b0010000;
    localparam ctl_t CTL_FLUSH  = 7'b1101110;
    localparam ctl_t CTL_STALL  = 7'b0000111;
    localparam ctl_t CTL_RUN    = 7'b1110010;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// hazard_ctrl_mc_if: ID-stage hazard controller bus.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = hazard_pkg::DEF_REG_AW
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic [REG_AW-1:0] ex_rt_i;
    logic              ex_memread_i;
    logic              branch_taken_i;
    logic              dmem_ready_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              ctrl_sel_o;
    logic              ifid_flush_o;
    logic              idex_flush_o;
    logic              pipe_en_o;
    logic              stall_o;
    logic [1:0]        state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;
`endif

    modport master (
        output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rt_i, ex_memread_i,
               branch_taken_i, dmem_ready_i,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt_o, flush_cnt_o,
`endif
        input  pc_write_o, ifid_write_o, ctrl_sel_o, ifid_flush_o, idex_flush_o,
               pipe_en_o, stall_o, state_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rt_i, ex_memread_i,
               branch_taken_i, dmem_ready_i,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt_o, flush_cnt_o,
`endif
        output pc_write_o, ifid_write_o, ctrl_sel_o, ifid_flush_o, idex_flush_o,
               pipe_en_o, stall_o, state_o
    );

endinterface

// File: rtl/hazard_cmp.sv
// hazard_cmp: load-use match of the EX load destination against ID sources, ignoring $0 and unused operands.
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_memread,
    output logic              hit
);

    assign hit = ex_memread && ex_rt != REG_AW'(ZERO_REG) &&
                 ((use_rs && ex_rt == id_rs) || (use_rt && ex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: multi-bubble load-use stall, multi-cycle branch flush and dmem freeze controller.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW       = DEF_REG_AW,
    parameter int LU_BUBBLES   = 1,
    parameter int BR_FLUSH_CYC = 1
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W      = 16
`endif
) (
    input logic             clk_i,
    input logic             rst_i,
    hazard_ctrl_mc_if.slave bus
);

    localparam logic [2:0] LU_LD = 3'(LU_BUBBLES - 1);
    localparam logic [2:0] BR_LD = 3'(BR_FLUSH_CYC - 1);

    if (LU_BUBBLES < 1 || LU_BUBBLES > 7 || BR_FLUSH_CYC < 1 || BR_FLUSH_CYC > 7) begin : g_bad_cfg
        $error("hazard_ctrl_mc: LU_BUBBLES and BR_FLUSH_CYC must be within 1..7");
    end

    state_t     st, st_n, sv, sv_n, eff;
    logic [2:0] cnt, cnt_n, cnt_dec;
    logic       hit;
    ctl_t       ctl;

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
        .id_rs      (bus.id_rs_i),
        .id_rt      (bus.id_rt_i),
        .use_rs     (bus.id_use_rs_i),
        .use_rt     (bus.id_use_rt_i),
        .ex_rt      (bus.ex_rt_i),
        .ex_memread (bus.ex_memread_i),
        .hit        (hit)
    );

    // While frozen the saved state is the one that resumes, so logic keys off eff.
    assign eff     = st == ST_MEM_WAIT ? sv : st;
    assign cnt_dec = cnt - 3'(cnt != 3'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st  <= ST_IDLE;
            sv  <= ST_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_n;
            sv  <= sv_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        st_n  = ST_IDLE;
        sv_n  = sv;
        cnt_n = '0;
        if (!bus.dmem_ready_i) begin
            st_n  = ST_MEM_WAIT;
            sv_n  = eff;
            cnt_n = cnt;
        end else if (bus.branch_taken_i) begin
            st_n  = BR_LD != 3'd0 ? ST_BR_FLUSH : ST_IDLE;
            cnt_n = BR_LD;
        end else if (eff == ST_LU_STALL || eff == ST_BR_FLUSH) begin
            st_n  = cnt_dec != 3'd0 ? eff : ST_IDLE;
            cnt_n = cnt_dec;
        end else if (hit) begin
            st_n  = LU_LD != 3'd0 ? ST_LU_STALL : ST_IDLE;
            cnt_n = LU_LD;
        end
    end

    // Mealy: a hazard seen in IDLE stalls in the same cycle it is detected.
    always_comb begin
        ctl = rst_i                                           ? CTL_RST    :
              !bus.dmem_ready_i                               ? CTL_FREEZE :
              bus.branch_taken_i                              ? CTL_FLUSH  :
              (eff == ST_LU_STALL || (eff == ST_IDLE && hit)) ? CTL_STALL  :
              eff == ST_BR_FLUSH                              ? CTL_FLUSH  : CTL_RUN;
    end

    assign bus.pc_write_o   = ctl.pc_write;
    assign bus.ifid_write_o = ctl.ifid_write;
    assign bus.ctrl_sel_o   = ctl.ctrl_sel;
    assign bus.ifid_flush_o = ctl.ifid_flush;
    assign bus.idex_flush_o = ctl.idex_flush;
    assign bus.pipe_en_o    = ctl.pipe_en;
    assign bus.stall_o      = ctl.stall;
    assign bus.state_o      = st;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctl.stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.dmem_ready_i && bus.branch_taken_i && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`endif

endmodule
